// File: rtl/alu_pkg.sv
// Shared types, framing constants and the CRC-3 helper for the ALU response stream.
package alu_pkg;

  localparam int unsigned PKT_BITS  = 11;
  localparam int unsigned DATA_PKTS = 4;

  typedef enum logic {
    PKT_DATA = 1'b0,
    PKT_CTL  = 1'b1
  } pkt_type_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_TYPE,
    RX_PAYLOAD,
    RX_STOP
  } rx_state_t;

  typedef struct packed {
    logic        err_rsp;
    logic [31:0] result;
    logic [3:0]  flags;
    logic [2:0]  crc_rx;
    logic        crc_ok;
    logic [5:0]  err_code;
    logic        par_ok;
  } alu_rsp_t;

  // CRC-3, poly x^3+x+1, init 0, message consumed MSB first.
  function automatic logic [2:0] crc3_37(input logic [36:0] d);
    logic [2:0]  c;
    logic [36:0] s;
    logic        fb;
    c = '0;
    s = d;
    for (int unsigned i = 0; i < 37; i++) begin
      fb = c[2] ^ s[36];
      c  = {c[1], c[0] ^ fb, fb};
      s  = s << 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/alu_pkt_rx.sv
// Bit-level receiver: frames one 11-bit packet from sout and reports type/payload or a stop error.
module alu_pkt_rx
  import alu_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      sout,
  output logic      pkt_done,
  output pkt_type_t pkt_type,
  output logic [7:0] payload,
  output logic      stop_err,
  output logic      rx_idle
);

  localparam int unsigned PAYLOAD_BITS = PKT_BITS - 3;

  rx_state_t  state;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       hunt;

  assign payload = shreg;
  assign rx_idle = (state == RX_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RX_IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      hunt     <= 1'b0;
      pkt_done <= 1'b0;
      stop_err <= 1'b0;
      pkt_type <= PKT_DATA;
    end else begin
      pkt_done <= 1'b0;
      stop_err <= 1'b0;
      case (state)
        // After a bad stop bit, wait for the line to go high before trusting a low as a start bit.
        RX_IDLE: begin
          if (sout) hunt <= 1'b0;
          else if (!hunt) state <= RX_TYPE;
        end
        RX_TYPE: begin
          pkt_type <= pkt_type_t'(sout);
          bit_cnt  <= '0;
          state    <= RX_PAYLOAD;
        end
        RX_PAYLOAD: begin
          shreg   <= {shreg[6:0], sout};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'(PAYLOAD_BITS - 1)) state <= RX_STOP;
        end
        RX_STOP: begin
          state <= RX_IDLE;
          if (sout) begin
            pkt_done <= 1'b1;
          end else begin
            stop_err <= 1'b1;
            hunt     <= 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/alu_rsp_deserializer.sv
// Assembles ALU response packets into one checked parallel response on a valid/ready port.
module alu_rsp_deserializer
  import alu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sout,
  input  logic        rsp_ready,
  output logic        rsp_valid,
  output logic        err_rsp,
  output logic [31:0] result,
  output logic [3:0]  flags,
  output logic [2:0]  crc_rx,
  output logic        crc_ok,
  output logic [5:0]  err_code,
  output logic        par_ok,
  output logic        frame_err,
  output logic        overrun
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic        pkt_done;
  pkt_type_t   pkt_type;
  logic [7:0]  payload;
  logic        stop_err;
  logic        rx_idle;

  logic [2:0]    pkt_cnt;
  logic [31:0]   res_q;
  logic [CW-1:0] idle_cnt;
  alu_rsp_t      rsp_q;
  alu_rsp_t      rsp_new;
  logic          done_ok;
  logic          bad_pkt;
  logic          idle_run;
  logic          timeout;

  alu_pkt_rx u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .sout     (sout),
    .pkt_done (pkt_done),
    .pkt_type (pkt_type),
    .payload  (payload),
    .stop_err (stop_err),
    .rx_idle  (rx_idle)
  );

  assign idle_run = rx_idle && (pkt_cnt != '0) && !pkt_done;
  assign timeout  = idle_run && (idle_cnt == CW'(TIMEOUT - 1));

  always_comb begin
    done_ok = 1'b0;
    bad_pkt = 1'b0;
    rsp_new = '0;
    if (pkt_done) begin
      if (pkt_type == PKT_CTL && payload[7]) begin
        if (pkt_cnt == '0) begin
          done_ok          = 1'b1;
          rsp_new.err_rsp  = 1'b1;
          rsp_new.err_code = payload[6:1];
          rsp_new.par_ok   = (payload[0] == ^{1'b1, payload[6:1]});
          rsp_new.crc_ok   = 1'b1;
        end else begin
          bad_pkt = 1'b1;
        end
      end else if (pkt_cnt < 3'(DATA_PKTS)) begin
        bad_pkt = (pkt_type == PKT_CTL);
      end else if (pkt_type == PKT_DATA) begin
        bad_pkt = 1'b1;
      end else begin
        done_ok        = 1'b1;
        rsp_new.result = res_q;
        rsp_new.flags  = payload[6:3];
        rsp_new.crc_rx = payload[2:0];
        rsp_new.crc_ok = (crc3_37({res_q, 1'b0, payload[6:3]}) == payload[2:0]);
        rsp_new.par_ok = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt   <= '0;
      res_q     <= '0;
      idle_cnt  <= '0;
      rsp_q     <= '0;
      rsp_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;

      if (stop_err || bad_pkt || timeout) begin
        frame_err <= 1'b1;
        pkt_cnt   <= '0;
      end else if (done_ok) begin
        pkt_cnt <= '0;
        // A transfer in this same cycle frees the register, so only a stalled consumer drops the new one.
        if (rsp_valid && !rsp_ready) begin
          overrun <= 1'b1;
        end else begin
          rsp_q     <= rsp_new;
          rsp_valid <= 1'b1;
        end
      end else if (pkt_done) begin
        pkt_cnt <= pkt_cnt + 3'd1;
        res_q   <= {res_q[23:0], payload};
      end

      if (idle_run && !timeout) idle_cnt <= idle_cnt + 1'b1;
      else idle_cnt <= '0;
    end
  end

  assign err_rsp  = rsp_q.err_rsp;
  assign result   = rsp_q.result;
  assign flags    = rsp_q.flags;
  assign crc_rx   = rsp_q.crc_rx;
  assign crc_ok   = rsp_q.crc_ok;
  assign err_code = rsp_q.err_code;
  assign par_ok   = rsp_q.par_ok;

endmodule
